// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8 shared types: sizes, FSM state enum and the
// round-robin pick helper used by the top.
package rr_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // First set request at or above ptr, wrapping 7 -> 0.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr
  );
    logic [IDX_W-1:0] cand;
    logic             hit;
    rr_pick = ptr;
    hit     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!hit && req[cand]) begin
        rr_pick = cand;
        hit     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter8_decoder3x8.sv
// 3-to-8 one-hot decoder with enable; i1_in is the index MSB,
// o1_out is the decode of index 0.
module decoder3x8
  import rr_arbiter8_pkg::*;
(
  input  logic i1_in,
  input  logic i2_in,
  input  logic i3_in,
  input  logic en_in,
  output logic o1_out,
  output logic o2_out,
  output logic o3_out,
  output logic o4_out,
  output logic o5_out,
  output logic o6_out,
  output logic o7_out,
  output logic o8_out
);

  logic [IDX_W-1:0]   sel;
  logic [NUM_REQ-1:0] dec;

  assign sel = {i1_in, i2_in, i3_in};

  // One-hot decode of sel, gated by the enable.
  always_comb begin
    dec      = '0;
    dec[sel] = en_in;
  end

  assign o1_out = dec[0];
  assign o2_out = dec[1];
  assign o3_out = dec[2];
  assign o4_out = dec[3];
  assign o5_out = dec[4];
  assign o6_out = dec[5];
  assign o7_out = dec[6];
  assign o8_out = dec[7];

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter, two-state FSM, registered outputs.
// Define RR_ARBITER8_HOLD_TIMEOUT_EN to enable the HOLD_MAX grant limit.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NUM_REQ-1:0]  req_in,
  input  logic                done_in,
  output logic [NUM_REQ-1:0]  gnt_out,
  output logic [IDX_W-1:0]    gnt_idx_out,
  output logic                gnt_valid_out,
  output logic                timeout_out
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arbiter8: HOLD_MAX must be 1..255");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, dec;
  logic               valid_q, grant_d;
  logic               rel;

`ifdef RR_ARBITER8_HOLD_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       tmo_q, tmo_d;
  logic       hold_hit;

  assign hold_hit = (hold_q == 8'(HOLD_MAX - 1));
`endif

  // Next-state, pointer, grantee index and hold-limit logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    rel     = 1'b0;
`ifdef RR_ARBITER8_HOLD_TIMEOUT_EN
    hold_d  = hold_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_in) begin
          state_d = GRANT;
          idx_d   = rr_pick(req_in, ptr_q);
`ifdef RR_ARBITER8_HOLD_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        rel = done_in || !req_in[idx_q];
`ifdef RR_ARBITER8_HOLD_TIMEOUT_EN
        // A normal release in the same cycle wins over the timeout.
        tmo_d  = hold_hit && !rel;
        rel    = rel || hold_hit;
        hold_d = hold_q + 8'd1;
`endif
        if (rel) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == GRANT);
  end

  decoder3x8 u_dec (
    .i1_in  (idx_d[2]),
    .i2_in  (idx_d[1]),
    .i3_in  (idx_d[0]),
    .en_in  (grant_d),
    .o1_out (dec[0]),
    .o2_out (dec[1]),
    .o3_out (dec[2]),
    .o4_out (dec[3]),
    .o5_out (dec[4]),
    .o6_out (dec[5]),
    .o7_out (dec[6]),
    .o8_out (dec[7])
  );

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef RR_ARBITER8_HOLD_TIMEOUT_EN
      hold_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= dec;
      valid_q <= grant_d;
`ifdef RR_ARBITER8_HOLD_TIMEOUT_EN
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign gnt_out       = gnt_q;
  assign gnt_idx_out   = idx_q;
  assign gnt_valid_out = valid_q;
`ifdef RR_ARBITER8_HOLD_TIMEOUT_EN
  assign timeout_out   = tmo_q;
`else
  assign timeout_out   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_rr_arbiter8;

  localparam int HM = 4;
`ifdef RR_ARBITER8_HOLD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt_out;
  logic [2:0] gnt_idx_out;
  logic       gnt_valid_out;
  logic       timeout_out;

  int vectors = 0;
  int miscompares = 0;

  bit m_gv = 0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_tmo = 0;

  rr_arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_in        (req),
    .done_in       (done),
    .gnt_out       (gnt_out),
    .gnt_idx_out   (gnt_idx_out),
    .gnt_valid_out (gnt_valid_out),
    .timeout_out   (timeout_out)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    g = m_gv ? 8'(1 << m_idx) : 8'h00;
    return {g, 3'(m_idx), m_gv, m_tmo};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {gnt_out, gnt_idx_out, gnt_valid_out, timeout_out};
  endfunction

  task automatic model_step();
    bit normal, timed, found;
    if (rst) begin
      m_gv = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_tmo = 0;
    end else if (!m_gv) begin
      m_tmo = 0;
      if (req != 8'h00) begin
        found = 0;
        for (int i = 0; i < 8; i++) begin
          if (!found && req[(m_ptr + i) % 8]) begin
            m_idx = (m_ptr + i) % 8;
            found = 1;
          end
        end
        m_gv = 1;
        m_hold = 1;
      end
    end else begin
      normal = done || !req[m_idx];
      timed = TMO_EN && (m_hold >= HM);
      if (normal || timed) begin
        m_gv = 0;
        m_ptr = (m_idx + 1) % 8;
        m_tmo = timed && !normal;
      end else begin
        m_hold++;
        m_tmo = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input logic [7:0] q, input bit d);
    rst = r; req = q; done = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 8'hFF, 1);
    drive(1, 8'hFF, 0);
    vectors++;
    if (obs_vec() !== 13'h0) begin
      miscompares++;
      $display("FAIL reset: got %h want 0", obs_vec());
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    drive(1, 8'h00, 0);
    drive(0, 8'h81, 0);
    vectors++;
    if (gnt_out !== 8'h01 || gnt_idx_out !== 3'd0 || gnt_valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_first: got gnt %h idx %0d want 01 idx 0", gnt_out, gnt_idx_out);
    end
    drive(0, 8'h81, 1);
    vectors++;
    if (gnt_out !== 8'h00 || gnt_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_bubble: got gnt %h valid %b want 00 0", gnt_out, gnt_valid_out);
    end
    drive(0, 8'h81, 0);
    vectors++;
    if (gnt_out !== 8'h80 || gnt_idx_out !== 3'd7) begin
      miscompares++;
      $display("FAIL basic_second: got gnt %h idx %0d want 80 idx 7", gnt_out, gnt_idx_out);
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL basic_model: got %h want %h", obs_vec(), exp_vec());
    end
    drive(0, 8'h00, 1);
  endtask

  task automatic test_rotation();
    drive(1, 8'h00, 0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 8'hFF, 0);
      vectors++;
      if (gnt_idx_out !== 3'(k % 8) || gnt_out !== 8'(1 << (k % 8))) begin
        miscompares++;
        $display("FAIL rotation_%0d: got idx %0d gnt %h want idx %0d", k, gnt_idx_out, gnt_out, k % 8);
      end
      drive(0, 8'hFF, 1);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rotation_rel_%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_drop();
    drive(1, 8'h00, 0);
    drive(0, 8'h18, 0);
    vectors++;
    if (gnt_idx_out !== 3'd3 || gnt_out !== 8'h08) begin
      miscompares++;
      $display("FAIL drop_grant: got idx %0d gnt %h want 3 08", gnt_idx_out, gnt_out);
    end
    drive(0, 8'h11, 0);
    vectors++;
    if (gnt_out !== 8'h00 || gnt_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_release: got gnt %h want 00", gnt_out);
    end
    drive(0, 8'h11, 0);
    vectors++;
    if (gnt_idx_out !== 3'd4 || gnt_out !== 8'h10) begin
      miscompares++;
      $display("FAIL drop_ptr: got idx %0d gnt %h want 4 10", gnt_idx_out, gnt_out);
    end
    drive(0, 8'h00, 1);
  endtask

  task automatic test_hold();
    int tmos, run, maxrun;
    tmos = 0; run = 0; maxrun = 0;
    drive(1, 8'h00, 0);
    for (int c = 0; c < 22; c++) begin
      drive(0, 8'h04, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL hold_cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (timeout_out === 1'b1) tmos++;
      run = (gnt_valid_out === 1'b1) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    vectors++;
    if (TMO_EN) begin
      if (tmos != 4 || maxrun != HM) begin
        miscompares++;
        $display("FAIL hold_limit: got %0d pulses run %0d want 4 run %0d", tmos, maxrun, HM);
      end
    end else begin
      if (tmos != 0 || maxrun < 20) begin
        miscompares++;
        $display("FAIL hold_persist: got %0d pulses run %0d want 0 run>=20", tmos, maxrun);
      end
    end
    drive(0, 8'h00, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 8'h00, 0);
    drive(0, 8'h20, 0);
    drive(0, 8'h20, 1);
    drive(0, 8'h20, 0);
    vectors++;
    if (gnt_idx_out !== 3'd5 || gnt_out !== 8'h20) begin
      miscompares++;
      $display("FAIL rstmid_grant: got idx %0d gnt %h want 5 20", gnt_idx_out, gnt_out);
    end
    drive(1, 8'h20, 0);
    vectors++;
    if (gnt_out !== 8'h00 || gnt_valid_out !== 1'b0 || gnt_idx_out !== 3'd0) begin
      miscompares++;
      $display("FAIL rstmid_drop: got gnt %h idx %0d want 00 0", gnt_out, gnt_idx_out);
    end
    drive(0, 8'h41, 0);
    vectors++;
    if (gnt_idx_out !== 3'd0 || gnt_out !== 8'h01) begin
      miscompares++;
      $display("FAIL rstmid_ptr: got idx %0d gnt %h want 0 01", gnt_idx_out, gnt_out);
    end
    drive(0, 8'h00, 1);
  endtask

  task automatic test_random();
    logic [7:0] q;
    bit r, d;
    q = 8'h00;
    drive(1, 8'h00, 0);
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 3) q = 8'($urandom);
      d = ($urandom_range(0, 3) == 0);
      drive(r, q, d);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_drop();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter HOLD_MAX, default 4: maximum consecutive cycles a grant may be held when HOLD_TIMEOUT_EN is defined; legal range 1..255.
REQ-002 Port clk_in, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_in, input, 1: reset, synchronous, active-high.
REQ-004 Port req_in, input, 8: request vector; bit k = requester k.
REQ-005 Port done_in, input, 1: current grantee finished; sampled only in GRANT.
REQ-006 Port gnt_out, output, 8: one-hot grant; all-zero when no grant.
REQ-007 Port gnt_idx_out, output, 3: encoded index of the current grantee; holds the last granted index when idle.
REQ-008 Port gnt_valid_out, output, 1: high while in GRANT.
REQ-009 Port timeout_out, output, 1: one-cycle pulse when a grant is force-released by the hold limit.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-011 In IDLE with req_in != 0, the block SHALL select the first set bit at or after ptr, searching upward with wrap 7->0, and enter GRANT on the next edge.
REQ-012 ptr SHALL be a 3-bit register equal to (last granted index + 1) mod 8.
REQ-013 Request-to-grant latency from IDLE SHALL be exactly 1 cycle.
REQ-014 In IDLE with req_in == 0, the FSM SHALL remain in IDLE.
REQ-015 In GRANT, gnt_out SHALL equal the one-hot decode of gnt_idx_out and gnt_valid_out SHALL be 1; outside GRANT, gnt_out and gnt_valid_out SHALL be 0.
REQ-016 GRANT SHALL release to IDLE on the next edge when done_in == 1 or req_in[gnt_idx_out] == 0.
REQ-017 On release, ptr SHALL update to gnt_idx_out+1 mod 8, so one idle bubble cycle separates consecutive grants.
REQ-018 Changes on req_in bits other than the grantee's SHALL NOT affect an active grant.
REQ-019 If done_in and a timeout occur in the same cycle, the release SHALL count as a normal release and timeout_out SHALL stay 0.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 When rst_in == 1 at an edge: state = IDLE, ptr = 0, gnt_idx_out = 0, gnt_out = 0, gnt_valid_out = 0, timeout_out = 0, hold counter = 0.
REQ-022 Reset SHALL take effect mid-grant, dropping gnt_out on the following edge regardless of done_in.
REQ-023 Reset SHALL dominate all other inputs in the same cycle.

Configuration
REQ-024 Macro RR_ARBITER8_HOLD_TIMEOUT_EN SHALL compile in the hold limit.
REQ-025 With the macro defined, a hold counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-026 With the macro defined, once a grant has lasted HOLD_MAX cycles without release, GRANT SHALL force-release and pulse timeout_out for 1 cycle.
REQ-027 Without the macro, there SHALL be no hold counter, timeout_out SHALL be tied to 0, and a grant SHALL persist until the REQ-016 condition.

Structure
REQ-028 Package rr_arbiter8_pkg SHALL hold: NUM_REQ = 8, IDX_W = 3, and the state enum {IDLE, GRANT}.
REQ-029 The one-hot grant SHALL be produced by one instance of sub-module decoder3x8, with index bit 2 driving i1_in (MSB) and output o1_out mapping to gnt_out[0].

Verification
REQ-030 Reset then req_in = 8'h81 -> grant index 0 one cycle later, gnt_out = 8'h01; after done_in -> idle bubble, then index 7, gnt_out = 8'h80.
REQ-031 req_in = 8'hFF held, done_in pulsed every grant -> grant indices cycle 0,1,2,...,7,0 with no repeats or skips.
REQ-032 Grant to index 3, then deassert req_in[3] with no done_in -> gnt_out = 0 next cycle; ptr = 4.
REQ-033 With macro defined, HOLD_MAX = 4, req_in = 8'h04, no done_in -> grant lasts 4 cycles, timeout_out pulses once, regrant to index 2 after the bubble; without the macro -> grant persists 20+ cycles with timeout_out = 0.
REQ-034 rst_in asserted during grant to index 5 -> gnt_out = 0 next edge; the next arbitration starts from ptr = 0.
